alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single calculator ALU (one-hot op encoding, `alu_busy_i` / 8-bit result) between two requesters, e.g. the keypad controller and a self-test/replay port. It does round-robin arbitration and captures operands. It sequences the ALU start/wait/complete handshake and returns a tagged result with an error code. Divide-by-zero and malformed ops are screened before the ALU is touched, and a watchdog aborts a hung ALU.

## Interface
- `TIMEOUT`, 64: max WAIT cycles with `alu_busy_i` high before abort (≥2).
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_i`  in  2  per-requester request, level, held until that requester's `done_o` bit.
- `op0_i`, `op1_i`  in  4  one-hot op: 1000 add, 0100 sub, 0010 mul, 0001 div.
- `a0_i`, `b0_i`, `a1_i`, `b1_i`  in  4 each  operands (a op b).
- `gnt_o`  out  2  one-hot; high from grant through the DONE cycle.
- `done_o`  out  2  one-hot, single-cycle completion pulse.
- `result_o`  out  8  result of last completed transaction; held until next DONE.
- `err_o`  out  2  00 ok, 01 div-by-zero, 10 bad op, 11 timeout; held with `result_o`.
- `alu_op_o`  out  4  ALU start: op one-hot for exactly one cycle (ISSUE), else 0000.
- `alu_a_o`, `alu_b_o`  out  4  captured operands, stable from ISSUE through WAIT.
- `alu_busy_i`  in  1  ALU busy.
- `alu_i`  in  8  ALU result, valid when `alu_busy_i` low after start.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: no requests → stay. Exactly one request → grant it. Both requesting → grant the requester not served last. `last` pointer resets to 1, so requester 0 wins the first tie. On grant, capture op/a/b of the winner into registers and update `last`.
- Screening at grant, using captured values:
  - Op not exactly one bit set → DONE with err 10, result 0x00.
  - Op = div and b = 0 → DONE with err 01, result 0x00.
  - Otherwise → ISSUE.
  - Screened transactions never drive `alu_op_o` non-zero.
- ISSUE (1 cycle): `alu_op_o` = captured op. Clear the watchdog counter. → WAIT.
- WAIT:
  - `alu_busy_i` low → latch `alu_i` into `result_o`, err 00, → DONE.
  - `alu_busy_i` high and counter = TIMEOUT−1 → result 0x00, err 11, → DONE.
  - Otherwise increment the counter.
  - The ALU contract is that busy is asserted in the cycle after the start pulse for multi-cycle ops. A combinational ALU simply keeps busy low.
- DONE (1 cycle): `done_o[g]` = 1, `gnt_o[g]` still 1. → IDLE. The next grant can occur the cycle after DONE at the earliest.
- Requester dropping `req_i` mid-transaction: ignored; the transaction completes and `done_o` still pulses.
- Operand inputs changing after grant: no effect (captured values used).
- Counter width is `$clog2(TIMEOUT)`. The counter never wraps because the abort fires first.

## Timing
- Reset values: state IDLE, `gnt_o`=00, `done_o`=00, `result_o`=0x00, `err_o`=00, `alu_op_o`=0000, `alu_a_o`/`alu_b_o`=0, counter 0, `last`=1.
- Reset asserted mid-transaction: next cycle is IDLE with all outputs at reset values. No `done_o` is issued for the aborted transaction.
- Normal path, with request seen in IDLE at cycle t:
  - `gnt_o` and `alu_op_o` valid at t+1 (ISSUE).
  - WAIT from t+2.
  - First WAIT cycle w with busy low → `done_o`/`result_o` at w+1.
  - Minimum latency, request to `done_o`: 3 cycles.
- Screened path: `gnt_o` and `done_o` both at t+1 (latency 1).
- Timeout: busy high through all TIMEOUT WAIT cycles → DONE at t+2+TIMEOUT.
- Back-to-back: a requester holding `req_i` past its `done_o` is re-arbitrated in the IDLE cycle after DONE. Round-robin guarantees the other requester, if waiting, is served in between.

## Test plan
- Single add, combinational ALU: req0, op 1000, a=3, b=4, busy always 0. Expect `alu_op_o`=1000 for exactly 1 cycle at t+1, `done_o`=01 at t+3, `result_o`=0x07, `err_o`=00.
- Tie and fairness: both requesters hold requests continuously. Expect grant order 0,1,0,1; `gnt_o` never 11; no ALU start while one is in flight.
- Div-by-zero: req1, op 0001, b=0. Expect `done_o`=10 at t+1, err 01, result 0x00, `alu_op_o` stays 0000. Repeat with op 0110 → err 10.
- Multi-cycle ALU: mul, a=0xF, b=0xF, busy high for 5 cycles after the start pulse. Expect result 0xE1 latched in the first busy-low cycle+1; operands stable throughout; `result_o` held afterwards.
- Watchdog: TIMEOUT=8, busy stuck high. Expect `done_o` at t+10, err 11, result 0x00. A following normal request completes correctly.
- Reset mid-WAIT: assert `rst` 2 cycles into WAIT. Expect all outputs at reset values the next cycle, no `done_o` pulse, and `last`=1: with both requesting, requester 0 is granted first.

Source files
------------

// File: rtl/alu_arbiter.sv
// Shares one calculator ALU between two requesters: round-robin grant, operand capture,
// pre-issue screening of bad ops / divide-by-zero, and a watchdog for a hung ALU.
module alu_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic [3:0] op0_i,
    input  logic [3:0] op1_i,
    input  logic [3:0] a0_i,
    input  logic [3:0] b0_i,
    input  logic [3:0] a1_i,
    input  logic [3:0] b1_i,
    output logic [1:0] gnt_o,
    output logic [1:0] done_o,
    output logic [7:0] result_o,
    output logic [1:0] err_o,
    output logic [3:0] alu_op_o,
    output logic [3:0] alu_a_o,
    output logic [3:0] alu_b_o,
    input  logic       alu_busy_i,
    input  logic [7:0] alu_i
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_DIV0    = 2'b01;
    localparam logic [1:0] ERR_BADOP   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;
    localparam logic [3:0] OP_DIV      = 4'b0001;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       done_q, done_d;
    logic [7:0]       result_q, result_d;
    logic [1:0]       err_q, err_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic [3:0]       a_q, a_d;
    logic [3:0]       b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;

    logic       win_idx;
    logic [1:0] win_gnt;
    logic [3:0] win_op;
    logic [3:0] win_a;
    logic [3:0] win_b;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    // On a tie the requester that was not served last wins.
    always_comb begin
        win_idx = 1'b0;
        case (req_i)
            2'b01:   win_idx = 1'b0;
            2'b10:   win_idx = 1'b1;
            2'b11:   win_idx = ~last_q;
            default: win_idx = 1'b0;
        endcase
        win_gnt = win_idx ? 2'b10 : 2'b01;
        win_op  = win_idx ? op1_i : op0_i;
        win_a   = win_idx ? a1_i  : a0_i;
        win_b   = win_idx ? b1_i  : b0_i;
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        done_d   = 2'b00;
        result_d = result_q;
        err_d    = err_q;
        alu_op_d = 4'b0000;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        last_d   = last_q;

        case (state_q)
            IDLE: begin
                if (req_i != 2'b00) begin
                    gnt_d  = win_gnt;
                    last_d = win_idx;
                    a_d    = win_a;
                    b_d    = win_b;
                    // Screened requests finish immediately and never start the ALU.
                    if (!is_onehot(win_op)) begin
                        state_d  = DONE;
                        done_d   = win_gnt;
                        err_d    = ERR_BADOP;
                        result_d = 8'h00;
                    end else if ((win_op == OP_DIV) && (win_b == 4'd0)) begin
                        state_d  = DONE;
                        done_d   = win_gnt;
                        err_d    = ERR_DIV0;
                        result_d = 8'h00;
                    end else begin
                        state_d  = ISSUE;
                        alu_op_d = win_op;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (!alu_busy_i) begin
                    result_d = alu_i;
                    err_d    = ERR_OK;
                    done_d   = gnt_q;
                    state_d  = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    result_d = 8'h00;
                    err_d    = ERR_TIMEOUT;
                    done_d   = gnt_q;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= 2'b00;
            done_q   <= 2'b00;
            result_q <= 8'h00;
            err_q    <= ERR_OK;
            alu_op_q <= 4'b0000;
            a_q      <= 4'd0;
            b_q      <= 4'd0;
            cnt_q    <= '0;
            last_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            err_q    <= err_d;
            alu_op_q <= alu_op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
        end
    end

    assign gnt_o    = gnt_q;
    assign done_o   = done_q;
    assign result_o = result_q;
    assign err_o    = err_q;
    assign alu_op_o = alu_op_q;
    assign alu_a_o  = a_q;
    assign alu_b_o  = b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter: requester drivers push expected results,
// a monitor pops them on done_o, and a behavioural ALU answers start pulses.
module tb_alu_arbiter;

    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_i = 2'b00;
    logic [3:0] op0_i = 4'd0, op1_i = 4'd0;
    logic [3:0] a0_i = 4'd0, b0_i = 4'd0, a1_i = 4'd0, b1_i = 4'd0;
    logic       alu_busy_i = 1'b0;
    logic [7:0] alu_i = 8'h00;
    logic [1:0] gnt_o, done_o, err_o;
    logic [7:0] result_o;
    logic [3:0] alu_op_o, alu_a_o, alu_b_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rst_seen = 1'b1;

    logic [9:0] exp_q0[$];
    logic [9:0] exp_q1[$];
    int         order_q[$];
    logic [3:0] exp_op[2];
    logic [3:0] exp_a[2];
    logic [3:0] exp_b[2];
    bit         exp_issue[2];
    int         lat_tab[2];

    alu_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .op0_i      (op0_i),
        .op1_i      (op1_i),
        .a0_i       (a0_i),
        .b0_i       (b0_i),
        .a1_i       (a1_i),
        .b1_i       (b1_i),
        .gnt_o      (gnt_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .err_o      (err_o),
        .alu_op_o   (alu_op_o),
        .alu_a_o    (alu_a_o),
        .alu_b_o    (alu_b_o),
        .alu_busy_i (alu_busy_i),
        .alu_i      (alu_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic logic [7:0] aluCompute(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            4'b1000: return {4'd0, a} + {4'd0, b};
            4'b0100: return {4'd0, a} - {4'd0, b};
            4'b0010: return {4'd0, a} * {4'd0, b};
            4'b0001: return (b == 4'd0) ? 8'hFF : ({4'd0, a} / {4'd0, b});
            default: return 8'h00;
        endcase
    endfunction

    // Expected {err, result} for one transaction, given how long the ALU stays busy.
    function automatic logic [9:0] refModel(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b, input int lat);
        if ($countones(op) != 1) return {2'b10, 8'h00};
        if (op == 4'b0001 && b == 4'd0) return {2'b01, 8'h00};
        if (lat >= TIMEOUT) return {2'b11, 8'h00};
        return {2'b00, aluCompute(op, a, b)};
    endfunction

    function automatic logic [3:0] randOp();
        logic [3:0] v;
        if ($urandom_range(0, 3) == 0) v = 4'($urandom_range(0, 15));
        else v = 4'b0001 << $urandom_range(0, 3);
        return v;
    endfunction

    task automatic checkReset();
        checkOutput("rst_gnt", gnt_o, 2'b00);
        checkOutput("rst_done", done_o, 2'b00);
        checkOutput("rst_result", result_o, 8'h00);
        checkOutput("rst_err", err_o, 2'b00);
        checkOutput("rst_alu_op", alu_op_o, 4'b0000);
        checkOutput("rst_alu_a", alu_a_o, 4'd0);
        checkOutput("rst_alu_b", alu_b_o, 4'd0);
    endtask

    task automatic applyStimulus(input int r, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                                 input int lat, input bit check_lat, input bit drop, input bit scramble);
        logic [9:0] expv;
        int c0, waited, want_lat;
        bit got;
        if (check_lat) @(negedge clk);
        expv = refModel(op, a, b, lat);
        exp_op[r]    = op;
        exp_a[r]     = a;
        exp_b[r]     = b;
        lat_tab[r]   = lat;
        exp_issue[r] = (expv[9:8] == 2'b00) || (expv[9:8] == 2'b11);
        if (expv[9:8] == 2'b11) want_lat = 2 + TIMEOUT;
        else if (exp_issue[r]) want_lat = 3 + lat;
        else want_lat = 1;
        if (r == 0) begin
            op0_i = op; a0_i = a; b0_i = b;
            exp_q0.push_back(expv);
        end else begin
            op1_i = op; a1_i = a; b1_i = b;
            exp_q1.push_back(expv);
        end
        req_i[r] = 1'b1;
        c0 = cyc;
        got = 1'b0;
        waited = 0;
        while (!got && waited < 300) begin
            @(negedge clk);
            waited++;
            if (done_o[r]) got = 1'b1;
            else if (scramble && gnt_o[r]) begin
                if (r == 0) begin
                    op0_i = 4'($urandom_range(0, 15)); a0_i = 4'($urandom_range(0, 15)); b0_i = 4'($urandom_range(0, 15));
                end else begin
                    op1_i = 4'($urandom_range(0, 15)); a1_i = 4'($urandom_range(0, 15)); b1_i = 4'($urandom_range(0, 15));
                end
                req_i[r] = 1'($urandom_range(0, 1));
            end
        end
        checkOutput("done_seen", got, 1);
        if (got && check_lat) checkOutput("latency", cyc - c0, want_lat);
        if (drop) req_i[r] = 1'b0;
    endtask

    task automatic randomRequester(input int r, input int n);
        bit held = 1'b0;
        bit drop;
        int lat;
        logic [3:0] b;
        for (int i = 0; i < n; i++) begin
            if (!held) repeat ($urandom_range(0, 3)) @(negedge clk);
            case ($urandom_range(0, 5))
                0: lat = 0;
                1: lat = 1;
                2: lat = 2;
                3: lat = 3;
                4: lat = TIMEOUT - 1;
                default: lat = TIMEOUT;
            endcase
            b = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            drop = (i == n - 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
            applyStimulus(r, randOp(), 4'($urandom_range(0, 15)), b, lat, 1'b0, drop, 1'b1);
            held = !drop;
        end
    endtask

    // Behavioural ALU: answers each start pulse, holding busy for the latency chosen by the owner.
    initial begin : alu_model
        int cnt;
        int g;
        bit inflight;
        logic [7:0] pend;
        logic [3:0] cur_a, cur_b;
        cnt = 0;
        inflight = 1'b0;
        pend = 8'h00;
        cur_a = 4'd0;
        cur_b = 4'd0;
        forever begin
            @(negedge clk);
            if (rst_seen) begin
                cnt = 0;
                inflight = 1'b0;
                alu_busy_i = 1'b0;
                alu_i = 8'h00;
            end else begin
                if (done_o != 2'b00) inflight = 1'b0;
                if (alu_op_o != 4'b0000) begin
                    g = gnt_o[1] ? 1 : 0;
                    checkOutput("alu_start_overlap", inflight, 0);
                    checkOutput("alu_start_unscreened", exp_issue[g], 1);
                    checkOutput("alu_op", alu_op_o, exp_op[g]);
                    checkOutput("alu_a", alu_a_o, exp_a[g]);
                    checkOutput("alu_b", alu_b_o, exp_b[g]);
                    inflight = 1'b1;
                    cur_a = exp_a[g];
                    cur_b = exp_b[g];
                    pend = aluCompute(alu_op_o, alu_a_o, alu_b_o);
                    if (lat_tab[g] == 0) begin
                        cnt = 0;
                        alu_busy_i = 1'b0;
                        alu_i = pend;
                    end else begin
                        cnt = lat_tab[g] + 1;
                        alu_busy_i = 1'b1;
                        alu_i = 8'hA5;
                    end
                end else if (cnt > 0) begin
                    if (done_o == 2'b00) begin
                        checkOutput("alu_a_stable", alu_a_o, cur_a);
                        checkOutput("alu_b_stable", alu_b_o, cur_b);
                    end
                    cnt--;
                    if (cnt == 0) begin
                        alu_busy_i = 1'b0;
                        alu_i = pend;
                    end
                end
            end
        end
    end

    // Monitor: pops the owner's expectation on every done pulse, checks holding otherwise.
    initial begin : monitor
        logic [9:0] held;
        logic [9:0] e;
        logic [1:0] prev_done;
        int r;
        held = 10'h000;
        prev_done = 2'b00;
        forever begin
            @(negedge clk);
            if (rst_seen) begin
                held = 10'h000;
            end else begin
                if (gnt_o != 2'b00) checkOutput("gnt_onehot", $countones(gnt_o), 1);
                if (done_o != 2'b00) begin
                    checkOutput("done_onehot", $countones(done_o), 1);
                    checkOutput("done_pulse", prev_done, 2'b00);
                    checkOutput("gnt_at_done", gnt_o, done_o);
                    r = done_o[1] ? 1 : 0;
                    order_q.push_back(r);
                    if (r == 0 && exp_q0.size() == 0) checkOutput("pending_txn0", exp_q0.size(), 1);
                    else if (r == 1 && exp_q1.size() == 0) checkOutput("pending_txn1", exp_q1.size(), 1);
                    else begin
                        e = (r == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        checkOutput("result", result_o, e[7:0]);
                        checkOutput("err", err_o, e[9:8]);
                        held = e;
                    end
                end else begin
                    checkOutput("result_hold", {err_o, result_o}, held);
                end
            end
            prev_done = done_o;
        end
    end

    initial begin : global_guard
        #2000000;
        $display("[TB] FAIL global_timeout: actual running required finished");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin : main
        lat_tab[0] = 0;
        lat_tab[1] = 0;
        exp_issue[0] = 1'b0;
        exp_issue[1] = 1'b0;
        repeat (3) @(negedge clk);
        checkReset();
        rst = 1'b0;

        $display("[TB] directed: add, screening, multi-cycle, watchdog");
        applyStimulus(0, 4'b1000, 4'd3, 4'd4, 0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1, 4'b0001, 4'd9, 4'd0, 0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1, 4'b0110, 4'd9, 4'd2, 0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1, 4'b0000, 4'd1, 4'd1, 0, 1'b1, 1'b1, 1'b0);
        applyStimulus(0, 4'b0010, 4'hF, 4'hF, 5, 1'b1, 1'b1, 1'b0);
        applyStimulus(0, 4'b0100, 4'd3, 4'd4, 1, 1'b1, 1'b1, 1'b0);
        applyStimulus(0, 4'b1000, 4'd7, 4'd7, TIMEOUT, 1'b1, 1'b1, 1'b0);
        applyStimulus(0, 4'b0001, 4'hE, 4'd3, TIMEOUT - 1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1, 4'b1000, 4'd2, 4'd5, 1, 1'b1, 1'b1, 1'b0);

        $display("[TB] fairness: both requesters held");
        order_q.delete();
        fork
            for (int i = 0; i < 4; i++)
                applyStimulus(0, 4'b0001 << $urandom_range(0, 3), 4'($urandom_range(0, 15)), 4'($urandom_range(1, 15)),
                              $urandom_range(0, 3), 1'b0, (i == 3), 1'b0);
            for (int j = 0; j < 4; j++)
                applyStimulus(1, 4'b0001 << $urandom_range(0, 3), 4'($urandom_range(0, 15)), 4'($urandom_range(1, 15)),
                              $urandom_range(0, 3), 1'b0, (j == 3), 1'b0);
        join
        checkOutput("fair_count", order_q.size(), 8);
        for (int k = 0; k < order_q.size(); k++) checkOutput("fair_order", order_q[k], k % 2);

        $display("[TB] reset in WAIT");
        @(negedge clk);
        op0_i = 4'b1000; a0_i = 4'd5; b0_i = 4'd6;
        exp_op[0] = 4'b1000; exp_a[0] = 4'd5; exp_b[0] = 4'd6;
        exp_issue[0] = 1'b1; lat_tab[0] = 6;
        req_i = 2'b01;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        req_i = 2'b11;
        @(negedge clk);
        checkReset();
        rst = 1'b0;
        order_q.delete();
        fork
            applyStimulus(0, 4'b0100, 4'd9, 4'd4, 0, 1'b0, 1'b1, 1'b0);
            applyStimulus(1, 4'b1000, 4'd1, 4'd1, 0, 1'b0, 1'b1, 1'b0);
        join
        checkOutput("rst_first_grant", order_q.size() > 0 ? order_q[0] : 9, 0);

        $display("[TB] random traffic");
        fork
            randomRequester(0, 25);
            randomRequester(1, 25);
        join
        repeat (3) @(negedge clk);
        checkOutput("drained0", exp_q0.size(), 0);
        checkOutput("drained1", exp_q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
